// File: rtl/mult_pkg.sv
// Shared definitions for the sequential signed multiplier: FSM state
// encoding and the default operand width.
package mult_pkg;

    localparam int W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/mult_abs.sv
// Two's-complement magnitude of a W-bit value as a W-bit unsigned number;
// the most negative input maps to 2^(W-1), which still fits in W bits.
module mult_abs
    import mult_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [W-1:0] value_i,
    output logic [W-1:0] mag_o
);

    localparam logic [W-1:0] ONE_W = W'(1);

    assign mag_o = value_i[W-1] ? (~value_i + ONE_W) : value_i;

endmodule

// File: rtl/mult_seq.sv
// Sequential signed multiplier: sign-magnitude shift-add, one partial
// product per clock, with the sign applied in a final cycle.
module mult_seq
    import mult_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   z,
    output logic             zf
);

    localparam int              CW     = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0]   ONE_C  = CW'(1);
    localparam logic [CW-1:0]   LAST_C = CW'(W - 1);
    localparam logic [2*W-1:0]  ONE_2W = (2*W)'(1);
    localparam logic [2*W-1:0]  ZERO_2W = '0;

    state_e           state_q, state_d;
    logic [W-1:0]     mag_a_q, mag_a_d;
    logic [W-1:0]     mag_b_q, mag_b_d;
    logic             sign_q, sign_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [2*W-1:0]   z_q, z_d;
    logic             zf_q, zf_d;
    logic             done_q, done_d;

    logic [W-1:0]     mag_a_s;
    logic [W-1:0]     mag_b_s;
    logic [2*W-1:0]   mag_a_ext_s;

    mult_abs #(.W(W)) u_abs_a (.value_i(a), .mag_o(mag_a_s));
    mult_abs #(.W(W)) u_abs_b (.value_i(b), .mag_o(mag_b_s));

    assign mag_a_ext_s = {{W{1'b0}}, mag_a_q};

    // Next-state and datapath update for the IDLE/CALC/FIN sequence
    always_comb begin
        state_d = state_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        sign_d  = sign_q;
        acc_d   = acc_q;
        count_d = count_q;
        z_d     = z_q;
        zf_d    = zf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mag_a_d = mag_a_s;
                    mag_b_d = mag_b_s;
                    sign_d  = a[W-1] ^ b[W-1];
                    acc_d   = ZERO_2W;
                    count_d = '0;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (mag_b_q[count_q]) begin
                    acc_d = acc_q + (mag_a_ext_s << count_q);
                end else begin
                    acc_d = acc_q;
                end
                count_d = count_q + ONE_C;
                if (count_q == LAST_C) begin
                    state_d = FIN;
                end else begin
                    state_d = CALC;
                end
            end
            FIN: begin
                // The magnitude product never exceeds 2^(2W-2), so negation cannot overflow
                z_d     = sign_q ? (~acc_q + ONE_2W) : acc_q;
                zf_d    = (z_d == ZERO_2W);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mag_a_q <= '0;
            mag_b_q <= '0;
            sign_q  <= 1'b0;
            acc_q   <= '0;
            count_q <= '0;
            z_q     <= '0;
            zf_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            sign_q  <= sign_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            z_q     <= z_d;
            zf_q    <= zf_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign z    = z_q;
    assign zf   = zf_q;

endmodule
